// File: rtl/div_signed_seq.sv
// Sequential signed divider: 2W-bit dividend / W-bit divisor, radix-2 non-restoring on magnitudes.
// Optional DIV_EXC_BYPASS_EN: divide-by-zero / precheck overflow skip CALC and finish in one edge.
module div_signed_seq #(
    parameter int W = 8
) (
    input  logic                  clk,
    input  logic                  clrn,
    input  logic                  start,
    input  logic signed [2*W-1:0] a,
    input  logic signed [W-1:0]   b,
    output logic signed [W-1:0]   q,
    output logic signed [W-1:0]   r,
    output logic                  busy,
    output logic                  ready,
    output logic                  ovf,
    output logic                  dbz
);
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    function automatic logic [2*W-1:0] mag_a(input logic signed [2*W-1:0] x);
        logic [2*W-1:0] u;
        u = x;
        return u[2*W-1] ? -u : u;
    endfunction

    function automatic logic [W-1:0] mag_b(input logic signed [W-1:0] x);
        logic [W-1:0] u;
        u = x;
        return u[W-1] ? -u : u;
    endfunction

    function automatic logic signed [W-1:0] apply_sign(input logic [W-1:0] m, input logic neg);
        return neg ? signed'(-m) : signed'(m);
    endfunction

    function automatic logic signed [W-1:0] sat_q(input logic neg);
        return neg ? signed'({1'b1, {(W-1){1'b0}}}) : signed'({1'b0, {(W-1){1'b1}}});
    endfunction

    state_t              state;
    logic [CW-1:0]       count;

    logic [2*W-1:0]      a_mag_in;
    logic [W-1:0]        b_mag_in;
    logic                pre_in;
    logic                accept;

    logic signed [W+1:0] p;
    logic [W-1:0]        qr;
    logic [W-1:0]        b_mag;
    logic                q_neg;
    logic                r_neg;
    logic                pre_ovf;
    logic                zero_div;

    logic signed [W+1:0] shifted;
    logic signed [W+1:0] b_ext;
    logic signed [W+1:0] step;
    logic [W-1:0]        r_mag;
    logic                q_big;

    assign a_mag_in = mag_a(a);
    assign b_mag_in = mag_b(b);
    // quotient magnitude needs more than W bits when the high half already reaches |b|
    assign pre_in   = a_mag_in[2*W-1:W] >= b_mag_in;
    assign accept   = (state == IDLE) && start;

    assign shifted  = {p[W:0], qr[W-1]};
    assign b_ext    = {2'b00, b_mag};
    assign step     = p[W+1] ? shifted + b_ext : shifted - b_ext;

    // final correction only needs the low W bits: the corrected remainder is in [0, |b|)
    assign r_mag    = p[W-1:0] + (p[W+1] ? b_mag : '0);
    assign q_big    = q_neg ? (qr > {1'b1, {(W-1){1'b0}}}) : qr[W-1];

    // accept edge loads magnitudes; CALC edges retire one quotient bit each
    always_ff @(posedge clk) begin
        if (accept) begin
            p        <= {2'b00, a_mag_in[2*W-1:W]};
            qr       <= a_mag_in[W-1:0];
            b_mag    <= b_mag_in;
            q_neg    <= a[2*W-1] ^ b[W-1];
            r_neg    <= a[2*W-1];
            pre_ovf  <= pre_in;
            zero_div <= (b == '0);
        end else if (state == CALC) begin
            p  <= step;
            qr <= {qr[W-2:0], ~step[W+1]};
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
            count <= '0;
            q     <= '0;
            r     <= '0;
            busy  <= 1'b0;
            ready <= 1'b0;
            ovf   <= 1'b0;
            dbz   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ready <= 1'b0;
                    if (start) begin
                        busy  <= 1'b1;
                        count <= CW'(W - 1);
`ifdef DIV_EXC_BYPASS_EN
                        state <= ((b == '0) || pre_in) ? FIX : CALC;
`else
                        state <= CALC;
`endif
                    end
                end
                CALC: begin
                    if (count == '0) begin
                        state <= FIX;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                FIX: begin
                    busy  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                    if (zero_div) begin
                        dbz <= 1'b1;
                        ovf <= 1'b0;
                        q   <= sat_q(r_neg);
                        r   <= '0;
                    end else if (pre_ovf || q_big) begin
                        dbz <= 1'b0;
                        ovf <= 1'b1;
                        q   <= sat_q(q_neg);
                        r   <= '0;
                    end else begin
                        dbz <= 1'b0;
                        ovf <= 1'b0;
                        q   <= apply_sign(qr, q_neg);
                        r   <= apply_sign(r_mag, r_neg);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_signed_seq.sv
// Bench for div_signed_seq (W=8): cycle-level behavioural model plus directed literal vectors.
module tb_div_signed_seq;
    localparam int W    = 8;
    localparam int QMAX = (1 << (W - 1)) - 1;
    localparam int QMIN = -(1 << (W - 1));
    localparam int LAT  = W + 1;

    logic                  clk = 1'b0;
    logic                  clrn;
    logic                  start;
    logic signed [2*W-1:0] a;
    logic signed [W-1:0]   b;
    logic signed [W-1:0]   q;
    logic signed [W-1:0]   r;
    logic                  busy;
    logic                  ready;
    logic                  ovf;
    logic                  dbz;

    always #5 clk = ~clk;

    div_signed_seq #(.W(W)) dut (
        .clk  (clk),
        .clrn (clrn),
        .start(start),
        .a    (a),
        .b    (b),
        .q    (q),
        .r    (r),
        .busy (busy),
        .ready(ready),
        .ovf  (ovf),
        .dbz  (dbz)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 60)
                $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic bit is_exc(input int av, input int bv);
        return (bv == 0) || (iabs(av) >= iabs(bv) * (1 << W));
    endfunction

    // Reference: truncating division, remainder follows dividend, saturate on range/zero
    task automatic ref_div(input int av, input int bv, output int eq, output int er,
                           output bit eo, output bit ed);
        int qt;
        eo = 0;
        ed = 0;
        if (bv == 0) begin
            ed = 1;
            eq = (av >= 0) ? QMAX : QMIN;
            er = 0;
        end else begin
            qt = av / bv;
            if (qt > QMAX || qt < QMIN) begin
                eo = 1;
                eq = ((av < 0) != (bv < 0)) ? QMIN : QMAX;
                er = 0;
            end else begin
                eq = qt;
                er = av % bv;
            end
        end
    endtask

    int m_rem   = 0;
    bit m_busy  = 0;
    bit m_ready = 0;
    bit m_ovf   = 0;
    bit m_dbz   = 0;
    int m_q     = 0;
    int m_r     = 0;
    int p_q, p_r;
    bit p_ovf, p_dbz;

    always @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            m_rem = 0; m_busy = 0; m_ready = 0; m_ovf = 0; m_dbz = 0; m_q = 0; m_r = 0;
        end else begin
            m_ready = 0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_ready = 1; m_busy = 0;
                    m_q = p_q; m_r = p_r; m_ovf = p_ovf; m_dbz = p_dbz;
                end
            end else if (start) begin
                ref_div(int'(a), int'(b), p_q, p_r, p_ovf, p_dbz);
                m_rem = LAT;
`ifdef DIV_EXC_BYPASS_EN
                if (is_exc(int'(a), int'(b))) m_rem = 1;
`endif
                m_busy = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",  int'(busy),  int'(m_busy));
            chk("ready", int'(ready), int'(m_ready));
            chk("q",     int'(q),     m_q);
            chk("r",     int'(r),     m_r);
            chk("ovf",   int'(ovf),   int'(m_ovf));
            chk("dbz",   int'(dbz),   int'(m_dbz));
        end
    end

    task automatic run_dir(input logic [2*W-1:0] av, input logic [W-1:0] bv,
                           input logic [W-1:0] eq, input logic [W-1:0] er,
                           input logic eo, input logic ed, input bit glitch);
        int n, nb, exp_lat;
        exp_lat = LAT;
`ifdef DIV_EXC_BYPASS_EN
        if (is_exc(int'($signed(av)), int'($signed(bv)))) exp_lat = 1;
`endif
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 16'($urandom); b = 8'($urandom);
        n = 0;
        nb = int'(busy);
        while (!ready && n < 40) begin
            @(posedge clk);
            n++;
            #1;
            if (busy) nb++;
            start = (glitch && n == 2);
            if (start) begin
                a = 16'h0001; b = 8'h01;
            end
        end
        start = 1'b0;
        chk("dir_latency", n, exp_lat);
        chk("dir_busy_cycles", nb, exp_lat);
        chk("dir_q",   int'($unsigned(q)), int'(eq));
        chk("dir_r",   int'($unsigned(r)), int'(er));
        chk("dir_ovf", int'(ovf), int'(eo));
        chk("dir_dbz", int'(dbz), int'(ed));
    endtask

    initial begin
        bit saw;
        clrn = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(ready), 0);
        chk("rst_q", int'(q), 0);
        chk("rst_r", int'(r), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_dbz", int'(dbz), 0);
        chk_en = 1;
        @(negedge clk);
        clrn = 1'b1;

        run_dir(16'h0064, 8'h07, 8'h0E, 8'h02, 0, 0, 1);
        run_dir(16'hFF9C, 8'h07, 8'hF2, 8'hFE, 0, 0, 0);
        run_dir(16'h0064, 8'hF9, 8'hF2, 8'h02, 0, 0, 0);
        run_dir(16'hFF9C, 8'hF9, 8'h0E, 8'hFE, 0, 0, 0);
        run_dir(16'h0005, 8'h00, 8'h7F, 8'h00, 0, 1, 0);
        run_dir(16'hFFFB, 8'h00, 8'h80, 8'h00, 0, 1, 0);
        run_dir(16'hFF80, 8'h01, 8'h80, 8'h00, 0, 0, 0);
        run_dir(16'h0080, 8'h01, 8'h7F, 8'h00, 1, 0, 0);
        run_dir(16'h0080, 8'hFF, 8'h80, 8'h00, 0, 0, 0);
        run_dir(16'h4000, 8'h02, 8'h7F, 8'h00, 1, 0, 0);
        run_dir(16'h8000, 8'h80, 8'h7F, 8'h00, 1, 0, 0);
        run_dir(16'h7FFF, 8'h80, 8'h80, 8'h00, 1, 0, 0);
        run_dir(16'hC000, 8'h80, 8'h7F, 8'h00, 1, 0, 0);
        run_dir(16'hFFFF, 8'h05, 8'h00, 8'hFF, 0, 0, 0);
        run_dir(16'hFFF6, 8'h05, 8'hFE, 8'h00, 0, 0, 0);
        run_dir(16'h0000, 8'h05, 8'h00, 8'h00, 0, 0, 0);

        // abort mid-operation
        @(negedge clk);
        a = 16'h0064; b = 8'h07; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        clrn = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_ready", int'(ready), 0);
        chk("abort_q", int'(q), 0);
        chk("abort_r", int'(r), 0);
        chk("abort_ovf", int'(ovf), 0);
        chk("abort_dbz", int'(dbz), 0);
        @(negedge clk);
        clrn = 1'b1;
        saw = 0;
        repeat (15) begin
            @(negedge clk);
            if (ready) saw = 1;
        end
        chk("abort_no_ready", int'(saw), 0);

        // start held high: operations run back to back
        repeat (45) begin
            @(negedge clk);
            start = 1'b1;
            a = 16'($signed(16'($urandom)) >>> $urandom_range(6, 12));
            b = 8'($urandom);
        end
        @(negedge clk);
        start = 1'b0;

        // randomized traffic with biased corner operands
        repeat (3000) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) == 0);
            a = 16'($signed(16'($urandom)) >>> $urandom_range(0, 15));
            b = 8'($urandom);
            case ($urandom_range(0, 9))
                0: b = 8'h00;
                1: b = ($urandom_range(0, 1) == 0) ? 8'h01 : 8'hFF;
                2: a = ($urandom_range(0, 1) == 0) ? 16'h8000 : 16'h7FFF;
                3: b = 8'h80;
                4: a = 16'(int'(b) * $urandom_range(0, 255));
                default: ;
            endcase
        end
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
